// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Shared definitions for the serial pattern detector:
//     - legal range of the pattern length (PAT_W_MIN .. PAT_W_MAX)
//     - legal range of the match counter width
//     - fill_t : fill-level type, wide enough for any legal pattern length
//     - fill_state_e : FSM view of the fill level (EMPTY / FILLING / ARMED)
//     - sat_inc : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  localparam int unsigned PAT_W_MIN   = 2;
  localparam int unsigned PAT_W_MAX   = 16;
  localparam int unsigned COUNT_W_MIN = 1;
  localparam int unsigned COUNT_W_MAX = 32;

  // $clog2(PAT_W+1) evaluated at the largest legal PAT_W, so one type
  // serves every instance regardless of its pattern length.
  localparam int unsigned FILL_W = $clog2(PAT_W_MAX + 1);
  typedef logic [FILL_W-1:0] fill_t;

  // Number of bits needed for a fill counter of a given pattern length.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    fill_width = $clog2(pat_w + 1);
  endfunction

  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_FILLING = 2'd1,
    FILL_ARMED   = 2'd2
  } fill_state_e;

  // Increment value, holding at all-ones of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] all_ones;
    all_ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    sat_inc  = (value == all_ones) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_shift_hist.sv
// -----------------------------------------------------------------------------
// shift_hist
//   W-bit serial history register. Newest bit enters at the LSB, so the
//   MSB is always the oldest bit held.
//
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset (history -> 0)
//     clr_i    in   synchronous clear (history -> 0), wins over en_i
//     en_i     in   shift d_i in on this edge
//     d_i      in   serial bit to shift in
//     shift_o  out  value the register would take if it shifted d_i now;
//                   lets the owner compare against a pattern on the same
//                   edge that captures the completing bit
// -----------------------------------------------------------------------------
module shift_hist #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] shift_o
);

  logic [W-1:0] hist_q;
  logic [W-1:0] hist_d;

  assign shift_o = {hist_q[W-2:0], d_i};

  always_comb begin
    hist_d = hist_q;
    if (clr_i) begin
      hist_d = '0;
    end else if (en_i) begin
      hist_d = shift_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
//   Bit-serial pattern detector. One bit is sampled per edge on which d_valid
//   is high; match pulses for one cycle after the edge whose bit completes
//   PATTERN (MSB = oldest bit). A saturating counter totals matches.
//
//   Parameters:
//     PAT_W    pattern length, 2..16
//     PATTERN  target sequence, MSB oldest, LSB newest
//     OVERLAP  1: bits of a completed match may begin the next one
//              0: history is considered empty after each match
//     COUNT_W  width of match_count, 1..32
//
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     d            in   serial data bit
//     d_valid      in   qualifies d (see stream comment below)
//     clear        in   synchronous flush of history, fill, counter, match
//     match        out  one-cycle pulse after the completing bit
//     match_count  out  matches since reset/clear, saturating
//     armed        out  history holds PAT_W valid bits
//
//   Stream: d_valid is a one-way qualifier with no back-pressure. d is
//   consumed on every rising edge where d_valid=1 and clear=0; edges with
//   d_valid=0 are gaps that leave history and fill untouched, so a pattern
//   may straddle any number of gap cycles.
// -----------------------------------------------------------------------------
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d,
  input  logic               d_valid,
  input  logic               clear,
  output logic               match,
  output logic [COUNT_W-1:0] match_count,
  output logic               armed
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_fsm: PAT_W out of range 2..16");
  end
  if (COUNT_W < COUNT_W_MIN || COUNT_W > COUNT_W_MAX) begin : g_bad_count_w
    $error("seq_detect_fsm: COUNT_W out of range 1..32");
  end

  localparam fill_t FILL_FULL = fill_t'(PAT_W);

  // ---------------------------------------------------------------------------
  // History window
  // ---------------------------------------------------------------------------
  logic [PAT_W-1:0] hist_shift;

  shift_hist #(
    .W (PAT_W)
  ) u_shift_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .en_i    (d_valid),
    .d_i     (d),
    .shift_o (hist_shift)
  );

  // ---------------------------------------------------------------------------
  // Fill-level FSM, match flag and counter
  // ---------------------------------------------------------------------------
  fill_t              fill_q;
  fill_t              fill_d;
  fill_t              fill_inc;
  fill_state_e        fill_state;
  logic               match_q;
  logic               match_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               hit;

  // The fill counter is the FSM state; the enum names its three regions.
  always_comb begin
    fill_state = FILL_FILLING;
    if (fill_q == '0) begin
      fill_state = FILL_EMPTY;
    end else if (fill_q == FILL_FULL) begin
      fill_state = FILL_ARMED;
    end
  end

  // Fill level after accepting one more bit; saturates once armed.
  always_comb begin
    fill_inc = fill_q + fill_t'(1);
    if (fill_state == FILL_ARMED) begin
      fill_inc = fill_q;
    end
  end

  // A hit needs a full window; stale history bits from before a reset,
  // clear or non-overlapping match never count because fill gates them.
  assign hit = (fill_inc == FILL_FULL) && (hist_shift == PATTERN);

  always_comb begin
    fill_d  = fill_q;
    match_d = 1'b0;
    count_d = count_q;
    if (clear) begin
      fill_d  = '0;
      count_d = '0;
    end else if (d_valid) begin
      fill_d = fill_inc;
      if (hit) begin
        match_d = 1'b1;
        count_d = COUNT_W'(sat_inc(32'(count_q), COUNT_W));
        if (!OVERLAP) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign armed       = (fill_state == FILL_ARMED);

endmodule

// File: doc/seq_detect_fsm.md
# seq_detect_fsm

Bit-serial pattern detector that consumes the single-bit registered data stream produced by the edge-triggered storage stage. It samples one bit per qualified clock edge, tracks how many valid bits are in its history window, and raises a one-cycle `match` pulse whenever the last `PAT_W` sampled bits equal `PATTERN`. A saturating match counter and a synchronous clear support interview-style sequence-detection exercises and their benches.

## Interface
- `PAT_W`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: target sequence; MSB is the oldest bit, LSB the newest.
- `OVERLAP`, 1: 1 means bits of a completed match may start the next match; 0 means the history is flushed after each match.
- `COUNT_W`, 8: width of `match_count`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d`  in  1  serial data bit, driven by the upstream registered stage.
- `d_valid`  in  1  `d` is sampled only on edges where this is 1.
- `clear`  in  1  synchronous flush of history, fill level, counter and `match`.
- `match`  out  1  one-cycle pulse; pattern completed by the last sampled bit.
- `match_count`  out  `COUNT_W`  number of matches since reset or clear; saturates.
- `armed`  out  1  history window holds `PAT_W` valid bits.

## Operation
- State: `hist[PAT_W-1:0]` (shift history), `fill` (0..`PAT_W`), `match`, `match_count`. `armed` is combinational: `fill == PAT_W`.
- FSM view of `fill`:
  - EMPTY (`fill`=0).
  - FILLING (1..`PAT_W`-1).
  - ARMED (`PAT_W`).
- Priority per edge: `rst_n` low, then `clear`, then `d_valid`, then hold.
- On an edge with `d_valid` set:
  - `next_hist = {hist[PAT_W-2:0], d}`.
  - `next_fill = min(fill+1, PAT_W)`.
  - Hit when `next_fill == PAT_W` and `next_hist == PATTERN`.
- On a hit:
  - `match` <= 1.
  - `match_count` <= `match_count`+1, unless it is already all-ones, in which case it holds.
  - If `OVERLAP`=0, `fill` <= 0. The `hist` contents become don't-care.
  - If `OVERLAP`=1, `fill` stays at `PAT_W`.
- No hit, or `d_valid`=0: `match` <= 0.
- `d_valid`=0 cycles are gaps. They do not break a pattern in progress, and `hist` and `fill` hold.
- `clear`: `hist`, `fill`, `match_count` <= 0 and `match` <= 0, regardless of `d_valid` on that edge. The bit on that edge is discarded.

## Timing
- Reset values: `match`=0, `match_count`=0, `armed`=0. Internally `hist`=0 and `fill`=0. Reset takes effect immediately when `rst_n` falls, with no clock needed.
- Latency: `match` is high for exactly the one cycle following the edge that sampled the completing bit.
- `match_count` updates on the same edge that sets `match`.
- Back-to-back matches are possible only with `OVERLAP`=1 and a self-overlapping `PATTERN`. In that case `match` stays high on consecutive cycles.
- Reset asserted mid-pattern discards all partial progress. After release, `PAT_W` fresh valid bits are needed before any match.
- `clear` asserted on the same edge as a completing bit gives no match and a counter of 0.
- `armed` rises on the edge where the `PAT_W`-th valid bit is sampled.
- `armed` with `OVERLAP`=0 falls on the edge after a match.

## Structure
- Package `seq_detect_pkg`:
  - Parameter legality check constants (`PAT_W_MIN`=2, `PAT_W_MAX`=16).
  - Function `sat_inc` (saturating increment).
  - Typedef for the `fill` width, `$clog2(PAT_W+1)`.
- One natural sub-module, `shift_hist`: a `PAT_W`-bit shift register with shift enable, synchronous clear and async active-low reset.
- Fill/match/counter logic stays in the top level.

## Test plan
- Defaults, `d_valid`=1, bits 1,0,1,1,0,1,1 → `match` pulses the cycle after bit 4 and after bit 7; `match_count`=2.
- Same stream with `OVERLAP`=0 → single pulse after bit 4; `match_count`=1; `armed`=0 after that match.
- Bits 1,0,1,1 with `d_valid`=0 for 3 cycles between each bit → exactly one pulse, after the 4th valid bit; no pulse in gap cycles.
- `COUNT_W`=2, five separate matches → `match_count` 1,2,3,3,3.
- `clear`=1 on the edge carrying the final 1 of 1,0,1,1 → no pulse, `match_count`=0, `armed`=0.
- `rst_n` pulsed low after bits 1,0,1 (no clock during reset), then bit 1 → no match; outputs 0 immediately at the falling edge of `rst_n`.
